// File: rtl/score_board.sv
// Guessing-game referee: captures per-channel |magic - guess| while counting,
// then scans the channels one per cycle to find the closest guess and any tie.
module score_board #(
  parameter  int NUM_USERS = 4,
  parameter  int CNT_W     = 8,
  parameter  int DIFF_W    = 5,
  localparam int WIN_W     = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic                        Clk100M,
  input  logic                        rstN,
  input  logic                        start,
  input  logic                        stop,
  input  logic [CNT_W-1:0]            magicSymbolCount,
  input  logic [NUM_USERS*CNT_W-1:0]  userCount,
  input  logic                        resultAck,
  output logic [NUM_USERS*DIFF_W-1:0] difference,
  output logic [WIN_W-1:0]            winner,
  output logic                        tie,
  output logic                        resultValid,
  output logic                        busy
);

  localparam int AW = (CNT_W + 1 > DIFF_W) ? CNT_W + 1 : DIFF_W;
  localparam logic [AW-1:0]    SAT_MAX  = (AW'(1) << DIFF_W) - AW'(1);
  localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(NUM_USERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIFF_W-1:0]   r_diff [NUM_USERS];
  logic [DIFF_W-1:0]   w_sat  [NUM_USERS];
  logic [WIN_W-1:0]    r_idx;
  logic [DIFF_W-1:0]   r_min;
  logic [WIN_W-1:0]    r_winner;
  logic                r_tie;
  logic                r_valid;
  logic [DIFF_W-1:0]   w_cur;
  logic                w_scan_last;

  assign w_cur       = r_diff[r_idx];
  assign w_scan_last = (r_state == S_SCAN) && (r_idx == LAST_IDX);

  always_ff @(posedge Clk100M or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_COUNT;
      S_COUNT: if (start) w_state_next = S_COUNT;
               else if (stop) w_state_next = S_SCAN;
      S_SCAN:  if (start) w_state_next = S_COUNT;
               else if (w_scan_last) w_state_next = S_DONE;
      S_DONE:  if (start) w_state_next = S_COUNT;
               else if (resultAck) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-channel difference capture; the stop cycle's sample is deliberately dropped.
  generate
    for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_chan
      logic [CNT_W:0] w_m;
      logic [CNT_W:0] w_u;
      logic [CNT_W:0] w_abs;
      logic [AW-1:0]  w_abs_ext;

      assign w_m       = {1'b0, magicSymbolCount};
      assign w_u       = {1'b0, userCount[gi*CNT_W +: CNT_W]};
      assign w_abs     = (w_m >= w_u) ? (w_m - w_u) : (w_u - w_m);
      assign w_abs_ext = AW'(w_abs);
      assign w_sat[gi] = (w_abs_ext > SAT_MAX) ? DIFF_W'(SAT_MAX) : DIFF_W'(w_abs_ext);

      always_ff @(posedge Clk100M or negedge rstN) begin
        if (!rstN) begin
          r_diff[gi] <= '0;
        end else if (start) begin
          r_diff[gi] <= '0;
        end else if ((r_state == S_COUNT) && !stop) begin
          r_diff[gi] <= w_sat[gi];
        end
      end

      assign difference[gi*DIFF_W +: DIFF_W] = r_diff[gi];
    end
  endgenerate

  always_ff @(posedge Clk100M or negedge rstN) begin
    if (!rstN) begin
      r_idx    <= '0;
      r_min    <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
      r_valid  <= 1'b0;
    end else if (start) begin
      r_idx    <= '0;
      r_min    <= '0;
      r_winner <= '0;
      r_tie    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_SCAN: begin
          r_idx <= w_scan_last ? '0 : r_idx + WIN_W'(1);
          // A strictly smaller value restarts tie tracking; lower index wins equal minima.
          if ((r_idx == '0) || (w_cur < r_min)) begin
            r_min    <= w_cur;
            r_winner <= r_idx;
            r_tie    <= 1'b0;
          end else if (w_cur == r_min) begin
            r_tie <= 1'b1;
          end
          if (w_scan_last) r_valid <= 1'b1;
        end
        S_DONE: if (resultAck) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign winner      = r_winner;
  assign tie         = r_tie;
  assign resultValid = r_valid;
  assign busy        = (r_state == S_COUNT) || (r_state == S_SCAN);

endmodule

// File: tb/tb_score_board.sv
// Randomized and directed bench for score_board; results are popped from a
// queue of model predictions by an independent monitor on each new resultValid.
module tb_score_board;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int DW = 5;
  localparam int WW = 2;

  typedef struct packed {
    logic [N*DW-1:0] diff;
    logic [WW-1:0]   win;
    logic            tie;
  } exp_t;

  logic            Clk100M = 1'b0;
  logic            rstN;
  logic            start, stop, resultAck;
  logic [CW-1:0]   magicSymbolCount;
  logic [N*CW-1:0] userCount;
  logic [N*DW-1:0] difference;
  logic [WW-1:0]   winner;
  logic            tie, resultValid, busy;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic prev_v = 1'b0;

  score_board #(.NUM_USERS(N), .CNT_W(CW), .DIFF_W(DW)) dut (
    .Clk100M(Clk100M), .rstN(rstN), .start(start), .stop(stop),
    .magicSymbolCount(magicSymbolCount), .userCount(userCount),
    .resultAck(resultAck), .difference(difference), .winner(winner),
    .tie(tie), .resultValid(resultValid), .busy(busy)
  );

  always #5 Clk100M = ~Clk100M;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: closest guess by plain integer arithmetic over the guesses.
  function automatic exp_t model(input int m, input logic [N*CW-1:0] u);
    exp_t e;
    int   d [N];
    int   best;
    int   nmin;
    best = 1 << 30;
    nmin = 0;
    e    = '0;
    for (int i = 0; i < N; i++) begin
      d[i] = m - int'(u[i*CW +: CW]);
      if (d[i] < 0) d[i] = -d[i];
      if (d[i] > 31) d[i] = 31;
      e.diff[i*DW +: DW] = DW'(d[i]);
      if (d[i] < best) best = d[i];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i] == best) begin
        e.win = WW'(i);
        nmin++;
      end
    end
    e.tie = (nmin > 1);
    return e;
  endfunction

  function automatic logic [N*CW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(negedge Clk100M);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge Clk100M);
    stop = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!resultValid && n < 50) begin
      @(negedge Clk100M);
      n++;
    end
  endtask

  task automatic ack_pulse();
    resultAck = 1'b1;
    @(negedge Clk100M);
    resultAck = 1'b0;
  endtask

  always @(negedge Clk100M) begin
    if (resultValid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got resultValid=1 expected no result pending");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("difference", 32'(difference), 32'(e.diff));
        chk("winner", 32'(winner), 32'(e.win));
        chk("tie", 32'(tie), 32'(e.tie));
        $display("result: winner=%0d tie=%0d difference=%h (exp %0d/%0d/%h)",
                 winner, tie, difference, e.win, e.tie, e.diff);
      end
    end
    prev_v <= resultValid;
  end

  initial begin
    int   n;
    exp_t e31;
    rstN = 1'b0; start = 1'b0; stop = 1'b0; resultAck = 1'b0;
    magicSymbolCount = '0; userCount = '0;
    repeat (2) @(negedge Clk100M);
    chk("reset_outputs", {resultValid, busy, tie, winner, difference}, 32'd0);
    rstN = 1'b1;

    // stop in IDLE is ignored
    do_stop();
    @(negedge Clk100M);
    chk("stop_in_idle", {busy, resultValid}, 32'd0);

    // magic 20 against {18,25,20,40}; resultAck during COUNT is ignored
    magicSymbolCount = 8'd20;
    userCount = pack4(18, 25, 20, 40);
    e31 = model(20, userCount);
    q.push_back(e31);
    start_pulse();
    ack_pulse();
    chk("ack_in_count_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge Clk100M);
    do_stop();
    wait_valid(n);
    chk("latency_basic", 32'(n), 32'd5);

    // held in DONE while resultAck stays low
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk100M);
      chk("hold_done", {resultValid, winner, tie, difference},
          {7'd0, 1'b1, e31.win, e31.tie, e31.diff});
    end
    ack_pulse();
    chk("ack_clears_valid", {resultValid, busy}, 32'd0);
    chk("diff_retained", 32'(difference), 32'(e31.diff));

    // saturation and tie: magic 10 against {7,13,200,13}
    magicSymbolCount = 8'd10;
    userCount = pack4(7, 13, 200, 13);
    q.push_back(model(10, userCount));
    start_pulse();
    repeat (3) @(negedge Clk100M);
    do_stop();
    wait_valid(n);
    chk("latency_tie", 32'(n), 32'd5);

    // start in DONE with resultAck high
    start = 1'b1; resultAck = 1'b1;
    @(negedge Clk100M);
    start = 1'b0; resultAck = 1'b0;
    chk("start_in_done", {resultValid, busy, 20'(difference)}, {10'd0, 1'b0, 1'b1, 20'd0});

    // start and stop together in COUNT restarts the round
    repeat (2) @(negedge Clk100M);
    start = 1'b1; stop = 1'b1;
    @(negedge Clk100M);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_same", {resultValid, busy, 20'(difference)}, {10'd0, 1'b0, 1'b1, 20'd0});
    q.push_back(model(10, userCount));
    repeat (2) @(negedge Clk100M);
    do_stop();
    wait_valid(n);
    chk("latency_restart", 32'(n), 32'd5);
    ack_pulse();

    // asynchronous reset in the middle of SCAN
    magicSymbolCount = 8'd50;
    userCount = pack4(1, 2, 3, 4);
    start_pulse();
    repeat (2) @(negedge Clk100M);
    do_stop();
    @(negedge Clk100M);
    #1 rstN = 1'b0;
    #1 chk("async_reset", {resultValid, busy, tie, winner, difference}, 32'd0);
    @(negedge Clk100M);
    rstN = 1'b1;
    q.delete();
    q.push_back(model(50, userCount));
    start_pulse();
    repeat (1) @(negedge Clk100M);
    do_stop();
    wait_valid(n);
    chk("latency_after_reset", 32'(n), 32'd5);
    ack_pulse();

    // randomized rounds, guesses often clustered near magic to provoke ties
    for (int r = 0; r < 20; r++) begin
      int m;
      int u [N];
      m = int'($urandom_range(0, 255));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          u[i] = m + int'($urandom_range(0, 6)) - 3;
          if (u[i] < 0) u[i] = 0;
          if (u[i] > 255) u[i] = 255;
        end else begin
          u[i] = int'($urandom_range(0, 255));
        end
      end
      magicSymbolCount = CW'(m);
      userCount = pack4(u[0], u[1], u[2], u[3]);
      q.push_back(model(m, userCount));
      start_pulse();
      repeat ($urandom_range(1, 5)) @(negedge Clk100M);
      do_stop();
      wait_valid(n);
      chk("latency_random", 32'(n), 32'd5);
      repeat ($urandom_range(0, 3)) @(negedge Clk100M);
      ack_pulse();
    end

    repeat (3) @(negedge Clk100M);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
